mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares a 4:1 one-bit mux datapath between four requesters.
- Grants one requester at a time and drives the mux select from that grant.
- Presents the selected bit downstream with a valid/ready handshake.
- Bounds each grant to HOLD_MAX accepted transfers so no requester can starve the others.

Parameters:
- HOLD_MAX, 8, maximum accepted transfers per grant before forced rotation; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  4  per-requester request; req[k] high means requester k has data on i[k].
- i  input  4  per-requester data bit.
- ready  input  1  downstream accepts o this cycle.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- s  output  2  mux select, registered; index of granted requester.
- o  output  1  selected data; equals i[s] in GRANT, 0 in IDLE (combinational).
- valid  output  1  transfer offered; equals req[s] in GRANT, 0 in IDLE (combinational).

Behaviour:
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the mux.
- Registered state:
  - state
  - s
  - gnt
  - last: 2-bit pointer to the most recently granted index
  - cnt: transfer counter, width clog2(HOLD_MAX+1)
- Reset (rst_n low, asynchronous) values:
  - state=IDLE, gnt=0000, s=00, last=11, cnt=0.
  - Requester 0 therefore has first priority after reset.
  - Outputs valid=0 and o=0 immediately.
- Transfer: occurs in any cycle with valid && ready. ready is ignored when valid=0.
- Round-robin pick: search indices last+1, last+2, last+3, last+4 (mod 4) over the eligible mask; the first set bit wins.
- IDLE:
  - If req != 0: next edge goes to GRANT with s=winner, gnt=onehot(winner), last=winner, cnt=0.
  - Latency from req rising to gnt is exactly 1 cycle.
- GRANT, release conditions at the current edge:
  - R1: req[s]=0.
  - R2: a transfer occurs and cnt==HOLD_MAX-1.
- GRANT, no release: cnt increments on each transfer and holds otherwise (ready low stalls without counting).
- On release:
  - Eligible mask:
    - For R1: req.
    - For R2: req with bit s cleared, unless no other bit is set, in which case req itself (the sole requester is re-granted).
  - If eligible != 0: switch directly to the winner with no idle cycle; cnt=0, last=winner.
  - Otherwise: go to IDLE, gnt=0000; s holds its last value.
- Simultaneous R1 and R2 cannot occur, because R2 requires req[s]=1.
- gnt is always one-hot or zero, and gnt[s]=1 whenever in GRANT.
- HOLD_MAX=1 rotates after every transfer.
- Counter never exceeds HOLD_MAX-1 and never wraps.
- Reset mid-grant: all state returns to reset values asynchronously; the first grant after rst_n deasserts starts from index 0 priority.

Test Plan:
1. Reset: rst_n low for 3 cycles with req=1111 -> gnt=0000, s=00, valid=0, o=0. After release: gnt=0001 on the 1st edge, then s=00, valid=1, o=i[0].
2. Single requester: req=0100, ready=1, HOLD_MAX=8 -> gnt=0100 after 1 cycle, o follows i[2]. After 8 transfers it is re-granted to 2 with cnt reset and no gap in valid.
3. Full contention: req=1111, ready=1, HOLD_MAX=8 -> grant order 0,1,2,3,0, each held exactly 8 transfers. Switch edges show no valid=0 cycle.
4. Stall: holding req[1] with ready=0 for 20 cycles -> gnt stays 0010, cnt stays 0, no rotation even with req=1111. Once ready=1, exactly 8 transfers occur, then gnt=0100.
5. Early drop: grant on 3, req goes 1001->0001 after 2 transfers -> next edge gnt=0001 (wrap from 3 to 0). With req=0000 instead -> IDLE, gnt=0000, valid=0.
6. Reset mid-grant: rst_n pulses low during a grant to 2 -> gnt=0000 immediately without a clock edge. After release with req=1111 -> gnt=0001.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 one-bit mux between four requesters.
// Each grant is limited to HOLD_MAX accepted transfers, then rotates.
//
//  state    | meaning
//  ---------+--------------------------------------------
//  ST_IDLE  | no requester owns the mux, gnt=0000
//  ST_GRANT | requester s owns the mux, gnt=onehot(s)
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] i,
    input  logic       ready,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       o,
    output logic       valid
);

    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic          r_state;
    logic [1:0]    r_s;
    logic [3:0]    r_gnt;
    logic [1:0]    r_last;
    logic [CW-1:0] r_cnt;

    logic       w_in_grant;
    logic       w_xfer;
    logic       w_rel_drop;
    logic       w_rel_quota;
    logic [3:0] w_others;
    logic [3:0] w_elig;
    logic       w_found;
    logic [1:0] w_win;

    assign w_in_grant = (r_state == ST_GRANT);
    assign valid      = w_in_grant & req[r_s];
    assign o          = w_in_grant & i[r_s];
    assign gnt        = r_gnt;
    assign s          = r_s;

    assign w_xfer      = valid & ready;
    assign w_rel_drop  = w_in_grant & ~req[r_s];
    assign w_rel_quota = w_xfer & (r_cnt == CNT_LAST);
    assign w_others    = req & ~(4'b0001 << r_s);

    // A quota release skips the current owner unless it is the only requester.
    always_comb begin
        w_elig = req;
        if (w_rel_quota && (w_others != 4'b0000)) begin
            w_elig = w_others;
        end
    end

    always_comb begin
        logic [1:0] v_idx;
        v_idx   = r_last;
        w_found = 1'b0;
        w_win   = r_last;
        for (int k = 1; k <= 4; k++) begin
            v_idx = r_last + 2'(k);
            if (!w_found && w_elig[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_s     <= 2'b00;
            r_gnt   <= 4'b0000;
            r_last  <= 2'b11;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_GRANT;
                        r_s     <= w_win;
                        r_gnt   <= 4'b0001 << w_win;
                        r_last  <= w_win;
                        r_cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_rel_drop || w_rel_quota) begin
                        if (w_found) begin
                            r_s    <= w_win;
                            r_gnt  <= 4'b0001 << w_win;
                            r_last <= w_win;
                            r_cnt  <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= 4'b0000;
                        end
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with HOLD_MAX=8.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] i;
    logic       ready;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       o;
    logic       valid;

    int tests;
    int fails;

    mux4_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .i     (i),
        .ready (ready),
        .gnt   (gnt),
        .s     (s),
        .o     (o),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = 4'b0000;
        i     = 4'b0000;
        ready = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = 4'b1111;
        i     = 4'b0101;
        ready = 1'b1;
        repeat (3) tick();
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        tests++; if (s !== 2'b00) begin fails++; $display("FAIL reset_s got=%b exp=00", s); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
        tests++; if (o !== 1'b0) begin fails++; $display("FAIL reset_o got=%b exp=0", o); end
        rst_n = 1'b1;
        #1;
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_noedge_gnt got=%b exp=0000", gnt); end
        tick();
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
        tests++; if (s !== 2'b00) begin fails++; $display("FAIL reset_first_s got=%b exp=00", s); end
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL reset_first_valid got=%b exp=1", valid); end
        tests++; if (o !== 1'b1) begin fails++; $display("FAIL reset_first_o got=%b exp=1", o); end
    endtask

    task automatic test_single;
        logic [3:0] pat [0:3];
        logic [3:0] v;
        pat[0] = 4'b0100; pat[1] = 4'b1011; pat[2] = 4'b1111; pat[3] = 4'b0000;
        do_reset();
        req   = 4'b0100;
        ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            v = pat[k % 4];
            i = v;
            #1;
            tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt cyc=%0d got=%b exp=0100", k, gnt); end
            tests++; if (valid !== 1'b1) begin fails++; $display("FAIL single_valid cyc=%0d got=%b exp=1", k, valid); end
            tests++; if (o !== v[2]) begin fails++; $display("FAIL single_o cyc=%0d got=%b exp=%b", k, o, v[2]); end
        end
    endtask

    task automatic test_contention;
        int order [0:4];
        logic [3:0] exp_g;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        do_reset();
        req   = 4'b1111;
        i     = 4'b1010;
        ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << order[g];
            for (int c = 0; c < 8; c++) begin
                tick();
                tests++; if (gnt !== exp_g) begin fails++; $display("FAIL contention_gnt slot=%0d cyc=%0d got=%b exp=%b", g, c, gnt, exp_g); end
                tests++; if (valid !== 1'b1) begin fails++; $display("FAIL contention_valid slot=%0d cyc=%0d got=%b exp=1", g, c, valid); end
            end
        end
    endtask

    task automatic test_stall;
        do_reset();
        req   = 4'b0010;
        ready = 1'b0;
        tick();
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL stall_first_gnt got=%b exp=0010", gnt); end
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL stall_hold_gnt cyc=%0d got=%b exp=0010", c, gnt); end
        end
        ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL stall_run_gnt cyc=%0d got=%b exp=0010", c, gnt); end
        end
        tick();
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL stall_rotate_gnt got=%b exp=0100", gnt); end
        tests++; if (s !== 2'd2) begin fails++; $display("FAIL stall_rotate_s got=%0d exp=2", s); end
    endtask

    task automatic test_early_drop;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            req   = 4'b1000;
            ready = 1'b1;
            tick();
            tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL drop_first_gnt pass=%0d got=%b exp=1000", pass, gnt); end
            req = 4'b1001;
            tick();
            tick();
            tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL drop_hold_gnt pass=%0d got=%b exp=1000", pass, gnt); end
            req = (pass == 0) ? 4'b0001 : 4'b0000;
            #1;
            tests++; if (valid !== 1'b0) begin fails++; $display("FAIL drop_valid_low pass=%0d got=%b exp=0", pass, valid); end
            tick();
            if (pass == 0) begin
                tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL drop_wrap_gnt got=%b exp=0001", gnt); end
                tests++; if (valid !== 1'b1) begin fails++; $display("FAIL drop_wrap_valid got=%b exp=1", valid); end
            end else begin
                tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL drop_idle_gnt got=%b exp=0000", gnt); end
                tests++; if (valid !== 1'b0) begin fails++; $display("FAIL drop_idle_valid got=%b exp=0", valid); end
                tests++; if (s !== 2'd3) begin fails++; $display("FAIL drop_idle_s got=%0d exp=3", s); end
            end
        end
    endtask

    task automatic test_priority;
        do_reset();
        req   = 4'b1010;
        ready = 1'b1;
        tick();
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL prio_gnt got=%b exp=0010", gnt); end
        tests++; if (s !== 2'd1) begin fails++; $display("FAIL prio_s got=%0d exp=1", s); end
        repeat (8) tick();
        tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL prio_next_gnt got=%b exp=1000", gnt); end
    endtask

    task automatic test_reset_mid_grant;
        do_reset();
        req   = 4'b0100;
        ready = 1'b1;
        tick();
        tick();
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL midrst_pre_gnt got=%b exp=0100", gnt); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL midrst_async_gnt got=%b exp=0000", gnt); end
        tests++; if (s !== 2'b00) begin fails++; $display("FAIL midrst_async_s got=%b exp=00", s); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL midrst_async_valid got=%b exp=0", valid); end
        req = 4'b1111;
        tick();
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL midrst_held_gnt got=%b exp=0000", gnt); end
        rst_n = 1'b1;
        tick();
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL midrst_after_gnt got=%b exp=0001", gnt); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        i     = 4'b0000;
        ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_early_drop();
        test_priority();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
